// File: rtl/cvxif_copro_queue.sv
// cvxif_copro_queue
//   CV-X-IF coprocessor with an in-flight queue. Instructions are decoded and
//   their results computed at issue. Each entry then waits for commit or kill.
//   Committed MULs spend MulLatency cycles in execution. Results retire in
//   order from the head of the queue through a valid/ready handshake.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   issue_valid_i        issue request; issue_ready_o = queue not full
//   issue_instr_i        instruction word
//   issue_id_i           instruction id
//   rs_i, rs_valid_i     source operands (rs1 in LSBs) and their valid flags
//   issue_accept_o       instruction accepted (combinational, handshake cycle)
//   issue_writeback_o    accepted instruction writes rd
//   commit_valid_i       commit event for commit_id_i; commit_kill_i discards
//   result_valid_o       head result available; result_ready_i takes it
//   result_id_o          id of the head result
//   result_data_o        value of the head result
//   result_rd_o          destination register of the head result
//   result_we_o          register write enable of the head result
//
// Entry states
//   state     | meaning
//   ST_WAIT   | accepted, waiting for commit or kill
//   ST_EXEC   | committed MUL, latency counter running
//   ST_DONE   | result ready to retire from the head
//   ST_KILLED | discarded, popped silently when it reaches the head

module cvxif_copro_queue #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned IdWidth     = 4,
   parameter int unsigned Depth       = 4,
   parameter int unsigned NrRgprPorts = 2,
   parameter int unsigned MulLatency  = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        issue_valid_i,
   output logic                        issue_ready_o,
   input  logic [31:0]                 issue_instr_i,
   input  logic [IdWidth-1:0]          issue_id_i,
   input  logic [NrRgprPorts*XLEN-1:0] rs_i,
   input  logic [NrRgprPorts-1:0]      rs_valid_i,
   output logic                        issue_accept_o,
   output logic                        issue_writeback_o,
   input  logic                        commit_valid_i,
   input  logic [IdWidth-1:0]          commit_id_i,
   input  logic                        commit_kill_i,
   output logic                        result_valid_o,
   input  logic                        result_ready_i,
   output logic [IdWidth-1:0]          result_id_o,
   output logic [XLEN-1:0]             result_data_o,
   output logic [4:0]                  result_rd_o,
   output logic                        result_we_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned LatW = (MulLatency > 1) ? $clog2(MulLatency + 1) : 1;

   localparam logic [6:0]      Opcode   = 7'b0001011;
   localparam logic [PtrW-1:0] PtrMax   = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
   // Cycles left in EXEC after the commit edge; the last decrement lands on DONE.
   localparam logic [LatW-1:0] MulLoad  = LatW'(MulLatency - 1);

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_EXEC,
      ST_DONE,
      ST_KILLED
   } ent_state_e;

   logic [Depth-1:0]   ent_valid;
   ent_state_e         ent_state [Depth];
   logic [IdWidth-1:0] ent_id    [Depth];
   logic [XLEN-1:0]    ent_data  [Depth];
   logic [4:0]         ent_rd    [Depth];
   logic [LatW-1:0]    ent_cnt   [Depth];
   logic [Depth-1:0]   ent_we;
   logic [Depth-1:0]   ent_mul;

   logic [PtrW-1:0]    head;
   logic [PtrW-1:0]    tail;
   logic [CntW-1:0]    count;

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [4:0]         rd;
   logic [XLEN-1:0]    rs1;
   logic [XLEN-1:0]    rs2;
   logic [XLEN-1:0]    rs3;
   logic               rs3_valid;
   logic               legal;
   logic               needs_rs3;
   logic               is_mul;
   logic               operands_ok;
   logic [XLEN-1:0]    exec_result;
   logic               handshake;
   logic               push;
   logic               pop;
   logic               head_done;
   logic               head_killed;
   logic               new_commit;
   logic               unused_instr_bits;

   assign opcode = issue_instr_i[6:0];
   assign rd     = issue_instr_i[11:7];
   assign funct3 = issue_instr_i[14:12];
   assign rs1    = rs_i[XLEN-1:0];
   assign rs2    = rs_i[2*XLEN-1:XLEN];

   assign unused_instr_bits = ^issue_instr_i[31:15];

   if (NrRgprPorts == 3) begin : g_rs3
      assign rs3       = rs_i[2*XLEN +: XLEN];
      assign rs3_valid = rs_valid_i[2];
   end else begin : g_no_rs3
      assign rs3       = '0;
      assign rs3_valid = 1'b0;
   end

   always_comb begin
      legal       = 1'b0;
      needs_rs3   = 1'b0;
      is_mul      = 1'b0;
      exec_result = '0;
      if (opcode == Opcode) begin
         case (funct3)
            3'b000: begin
               legal       = 1'b1;
               exec_result = rs1 + rs2;
            end
            3'b001: begin
               legal       = 1'b1;
               exec_result = rs1 - rs2;
            end
            3'b010: begin
               legal       = 1'b1;
               exec_result = rs1 ^ rs2;
            end
            3'b011: begin
               legal       = 1'b1;
               is_mul      = 1'b1;
               exec_result = rs1 * rs2;
            end
            3'b100: begin
               if (NrRgprPorts == 3) begin
                  legal       = 1'b1;
                  needs_rs3   = 1'b1;
                  exec_result = rs1 + rs2 + rs3;
               end
            end
            default: ;
         endcase
      end
   end

   assign operands_ok = rs_valid_i[0] && rs_valid_i[1] && (!needs_rs3 || rs3_valid);

   assign issue_ready_o     = (count < DepthCnt);
   assign handshake         = issue_valid_i && issue_ready_o;
   assign push              = handshake && legal && operands_ok;
   assign issue_accept_o    = push;
   assign issue_writeback_o = push && (rd != 5'd0);

   // A commit aimed at the instruction being issued this cycle applies to it.
   assign new_commit = commit_valid_i && (commit_id_i == issue_id_i);

   assign head_done   = ent_valid[head] && (ent_state[head] == ST_DONE);
   assign head_killed = ent_valid[head] && (ent_state[head] == ST_KILLED);
   assign pop         = (head_done && result_ready_i) || head_killed;

   assign result_valid_o = head_done;
   assign result_id_o    = head_done ? ent_id[head]   : '0;
   assign result_data_o  = head_done ? ent_data[head] : '0;
   assign result_rd_o    = head_done ? ent_rd[head]   : '0;
   assign result_we_o    = head_done && ent_we[head];

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrMax) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         ent_we    <= '0;
         ent_mul   <= '0;
         for (int i = 0; i < Depth; i++) begin
            ent_state[i] <= ST_WAIT;
            ent_id[i]    <= '0;
            ent_data[i]  <= '0;
            ent_rd[i]    <= '0;
            ent_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < Depth; i++) begin
            if (ent_valid[i]) begin
               if (ent_state[i] == ST_WAIT && commit_valid_i && ent_id[i] == commit_id_i) begin
                  if (commit_kill_i) begin
                     ent_state[i] <= ST_KILLED;
                  end else if (ent_mul[i] && MulLatency > 1) begin
                     ent_state[i] <= ST_EXEC;
                     ent_cnt[i]   <= MulLoad;
                  end else begin
                     // Single-cycle ops finish their EXEC cycle on the commit edge.
                     ent_state[i] <= ST_DONE;
                  end
               end else if (ent_state[i] == ST_EXEC) begin
                  if (ent_cnt[i] == LatW'(1)) begin
                     ent_state[i] <= ST_DONE;
                  end else begin
                     ent_cnt[i] <= ent_cnt[i] - 1'b1;
                  end
               end
            end
         end

         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= ptr_inc(head);
         end

         // Push never targets the head being popped: a push needs a free slot.
         if (push) begin
            ent_valid[tail] <= 1'b1;
            ent_id[tail]    <= issue_id_i;
            ent_data[tail]  <= exec_result;
            ent_rd[tail]    <= rd;
            ent_we[tail]    <= (rd != 5'd0);
            ent_mul[tail]   <= is_mul;
            ent_cnt[tail]   <= '0;
            if (new_commit && commit_kill_i) begin
               ent_state[tail] <= ST_KILLED;
            end else if (new_commit && is_mul && MulLatency > 1) begin
               ent_state[tail] <= ST_EXEC;
               ent_cnt[tail]   <= MulLoad;
            end else if (new_commit) begin
               ent_state[tail] <= ST_DONE;
            end else begin
               ent_state[tail] <= ST_WAIT;
            end
            tail <= ptr_inc(tail);
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cvxif_copro_queue.sv
// Testbench for cvxif_copro_queue: directed scenarios plus randomized traffic
// checked against a cycle-numbered queue model of the in-order retirement rules.

module tb_cvxif_copro_queue;

   localparam int XLEN    = 64;
   localparam int IDW     = 4;
   localparam int DEPTH   = 4;
   localparam int NRP     = 2;
   localparam int MUL_LAT = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              issue_valid;
   logic              issue_ready;
   logic [31:0]       issue_instr;
   logic [IDW-1:0]    issue_id;
   logic [NRP*XLEN-1:0] rs;
   logic [NRP-1:0]    rs_valid;
   logic              accept;
   logic              wb;
   logic              commit_valid;
   logic [IDW-1:0]    commit_id;
   logic              commit_kill;
   logic              rv;
   logic              result_ready;
   logic [IDW-1:0]    result_id;
   logic [XLEN-1:0]   result_data;
   logic [4:0]        result_rd;
   logic              result_we;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cvxif_copro_queue #(
      .XLEN(XLEN), .IdWidth(IDW), .Depth(DEPTH), .NrRgprPorts(NRP), .MulLatency(MUL_LAT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .issue_instr_i(issue_instr), .issue_id_i(issue_id),
      .rs_i(rs), .rs_valid_i(rs_valid),
      .issue_accept_o(accept), .issue_writeback_o(wb),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .result_valid_o(rv), .result_ready_i(result_ready),
      .result_id_o(result_id), .result_data_o(result_data),
      .result_rd_o(result_rd), .result_we_o(result_we)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [IDW-1:0]  id;
      logic [XLEN-1:0] data;
      logic [4:0]      rd;
      logic            we;
      int              lat;
      bit              committed;
      bit              killed;
      int              ready_cyc;
      int              kill_cyc;
   } ent_t;

   ent_t mq[$];
   int   cyc = 0;

   function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
      return {17'd0, f3, rd, 7'b0001011};
   endfunction

   task automatic ref_decode(input logic [31:0] ins, input logic [NRP-1:0] v,
                             input logic [NRP*XLEN-1:0] ops,
                             output bit ok, output logic [XLEN-1:0] d, output int lat);
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      a = ops[XLEN-1:0];
      b = ops[2*XLEN-1:XLEN];
      ok = 0;
      d = '0;
      lat = 1;
      if (ins[6:0] == 7'b0001011 && v == 2'b11) begin
         case (ins[14:12])
            3'd0: begin ok = 1; d = a + b; end
            3'd1: begin ok = 1; d = a - b; end
            3'd2: begin ok = 1; d = a ^ b; end
            3'd3: begin ok = 1; d = a * b; lat = MUL_LAT; end
            default: ok = 0;
         endcase
      end
   endtask

   function automatic bit m_rv();
      return (mq.size() > 0) && mq[0].committed && !mq[0].killed && (cyc >= mq[0].ready_cyc);
   endfunction

   function automatic bit m_silent();
      return (mq.size() > 0) && mq[0].killed && (cyc > mq[0].kill_cyc);
   endfunction

   // Advance one clock edge with the inputs currently driven and update the model.
   task automatic step();
      bit ok, acc, exp_rv, sil, found;
      logic [XLEN-1:0] d;
      int lat;
      ent_t e;
      ref_decode(issue_instr, rs_valid, rs, ok, d, lat);
      acc    = issue_valid && (mq.size() < DEPTH) && ok;
      exp_rv = m_rv();
      sil    = m_silent();
      @(posedge clk);
      found = 0;
      if (commit_valid) begin
         foreach (mq[k]) begin
            if (!found && mq[k].id == commit_id && !mq[k].committed) begin
               found = 1;
               mq[k].committed = 1;
               mq[k].killed    = commit_kill;
               mq[k].ready_cyc = cyc + mq[k].lat;
               mq[k].kill_cyc  = cyc;
            end
         end
      end
      if ((exp_rv && result_ready) || sil) void'(mq.pop_front());
      if (acc) begin
         e.id = issue_id;
         e.data = d;
         e.rd = issue_instr[11:7];
         e.we = (issue_instr[11:7] != 5'd0);
         e.lat = lat;
         e.committed = 0;
         e.killed = 0;
         e.ready_cyc = 0;
         e.kill_cyc = 0;
         if (commit_valid && commit_id == issue_id) begin
            e.committed = 1;
            e.killed    = commit_kill;
            e.ready_cyc = cyc + lat;
            e.kill_cyc  = cyc;
         end
         mq.push_back(e);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle();
      issue_valid  = 0;
      issue_instr  = '0;
      issue_id     = '0;
      rs           = '0;
      rs_valid     = '0;
      commit_valid = 0;
      commit_id    = '0;
      commit_kill  = 0;
   endtask

   task automatic set_issue(input logic [2:0] f3, input logic [4:0] rd, input logic [IDW-1:0] id,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [NRP-1:0] v);
      issue_valid = 1;
      issue_instr = mk_instr(f3, rd);
      issue_id    = id;
      rs          = {b, a};
      rs_valid    = v;
   endtask

   task automatic do_reset();
      idle();
      result_ready = 1;
      rst_n = 0;
      mq.delete();
      cyc = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
      checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_result_valid got=%b exp=0", rv); end
      checks++; if ({accept, wb, result_we, result_rd, result_id, result_data} !== '0) begin
         errors++; $display("FAIL reset_outputs got acc=%b wb=%b we=%b rd=%0d id=%0d data=%h exp all 0",
                            accept, wb, result_we, result_rd, result_id, result_data);
      end
   endtask

   task automatic test_add();
      set_issue(3'd0, 5'd3, 4'd1, 64'd5, 64'd7, 2'b11);
      #1;
      checks++; if ({accept, wb} !== 2'b11) begin errors++; $display("FAIL add_accept got=%b%b exp=11", accept, wb); end
      step();
      idle(); commit_valid = 1; commit_id = 4'd1; result_ready = 1;
      #1;
      checks++; if (rv !== 1'b0) begin errors++; $display("FAIL add_early got=%b exp=0", rv); end
      step();
      idle();
      #1;
      checks++; if ({rv, result_id, result_data, result_rd, result_we} !== {1'b1, 4'd1, 64'd12, 5'd3, 1'b1}) begin
         errors++; $display("FAIL add_result got v=%b id=%0d data=%0d rd=%0d we=%b exp v=1 id=1 data=12 rd=3 we=1",
                            rv, result_id, result_data, result_rd, result_we);
      end
      step();
      #1;
      checks++; if (rv !== 1'b0) begin errors++; $display("FAIL add_popped got=%b exp=0", rv); end
   endtask

   task automatic test_mul();
      set_issue(3'd3, 5'd4, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11);
      #1;
      checks++; if (accept !== 1'b1) begin errors++; $display("FAIL mul_accept got=%b exp=1", accept); end
      step();
      idle(); commit_valid = 1; commit_id = 4'd2;
      step();
      idle();
      for (int k = 1; k <= MUL_LAT; k++) begin
         #1;
         checks++; if (rv !== (k == MUL_LAT)) begin errors++; $display("FAIL mul_latency cycle=C+%0d got=%b exp=%b", k, rv, (k == MUL_LAT)); end
         if (k == MUL_LAT) begin
            checks++; if ({result_id, result_data} !== {4'd2, 64'hFFFF_FFFF_FFFF_FFFE}) begin
               errors++; $display("FAIL mul_data got id=%0d data=%h exp id=2 data=fffffffffffffffe", result_id, result_data);
            end
         end
         step();
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) begin
         set_issue(3'd0, (i == 0) ? 5'd0 : 5'(i + 10), 4'(i), 64'(i), 64'd1, 2'b11);
         #1;
         if (i == 0) begin
            checks++; if ({accept, wb} !== 2'b10) begin errors++; $display("FAIL wb_rd0 got=%b%b exp=10", accept, wb); end
         end
         step();
      end
      idle();
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", issue_ready); end
      set_issue(3'd0, 5'd5, 4'd5, 64'd1, 64'd1, 2'b11);
      #1;
      checks++; if ({accept, wb} !== 2'b00) begin errors++; $display("FAIL full_no_accept got=%b%b exp=00", accept, wb); end
      step();
      idle(); commit_valid = 1; commit_id = 4'd0; result_ready = 1;
      step();
      idle();
      #1;
      checks++; if ({rv, result_id, result_data, result_we} !== {1'b1, 4'd0, 64'd1, 1'b0}) begin
         errors++; $display("FAIL full_head got v=%b id=%0d data=%0d we=%b exp v=1 id=0 data=1 we=0", rv, result_id, result_data, result_we);
      end
      step();
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL ready_after_drain got=%b exp=1", issue_ready); end
      for (int i = 1; i < DEPTH; i++) begin
         idle(); commit_valid = 1; commit_id = 4'(i); commit_kill = 1;
         step();
      end
      idle();
      repeat (3) begin
         #1;
         checks++; if (rv !== 1'b0) begin errors++; $display("FAIL killed_no_result got=%b exp=0", rv); end
         step();
      end
   endtask

   task automatic test_kill();
      set_issue(3'd2, 5'd6, 4'd4, 64'hF0, 64'hFF, 2'b11);
      step();
      set_issue(3'd0, 5'd7, 4'd5, 64'd1, 64'd2, 2'b11);
      step();
      idle(); commit_valid = 1; commit_id = 4'd4; commit_kill = 1; result_ready = 1;
      #1;
      checks++; if (rv !== 1'b0) begin errors++; $display("FAIL kill_cycle got=%b exp=0", rv); end
      step();
      idle(); commit_valid = 1; commit_id = 4'd5;
      #1;
      checks++; if (rv !== 1'b0) begin errors++; $display("FAIL kill_silent_pop got=%b exp=0", rv); end
      step();
      idle();
      #1;
      checks++; if ({rv, result_id, result_data, result_rd} !== {1'b1, 4'd5, 64'd3, 5'd7}) begin
         errors++; $display("FAIL kill_survivor got v=%b id=%0d data=%0d rd=%0d exp v=1 id=5 data=3 rd=7", rv, result_id, result_data, result_rd);
      end
      step();
      #1;
      checks++; if (rv !== 1'b0) begin errors++; $display("FAIL kill_empty got=%b exp=0", rv); end
   endtask

   task automatic test_reject_back_to_back();
      logic [XLEN-1:0] exp_d [4];
      exp_d[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_d[1] = 64'd99;
      exp_d[2] = 64'd98;
      exp_d[3] = 64'hFF;
      for (int i = 0; i < 3; i++) begin
         set_issue(3'd1, 5'(20 + i), 4'(8 + i), (i == 0) ? 64'd1 : 64'd100, (i == 0) ? 64'd2 : 64'(i), 2'b11);
         step();
      end
      for (int r = 0; r < 4; r++) begin
         case (r)
            0: set_issue(3'd4, 5'd9, 4'd11, 64'd1, 64'd1, 2'b11);
            1: set_issue(3'd0, 5'd9, 4'd11, 64'd1, 64'd1, 2'b01);
            2: set_issue(3'd5, 5'd9, 4'd11, 64'd1, 64'd1, 2'b11);
            default: begin
               set_issue(3'd0, 5'd9, 4'd11, 64'd1, 64'd1, 2'b11);
               issue_instr[6:0] = 7'b0110011;
            end
         endcase
         #1;
         checks++; if ({accept, wb} !== 2'b00) begin errors++; $display("FAIL reject_%0d got=%b%b exp=00", r, accept, wb); end
         step();
      end
      set_issue(3'd2, 5'd23, 4'd11, 64'hAA, 64'h55, 2'b11);
      #1;
      checks++; if (accept !== 1'b1) begin errors++; $display("FAIL legal_after_reject got=%b exp=1", accept); end
      step();
      idle();
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reject_count_unchanged got=%b exp=0", issue_ready); end
      for (int c = 0; c <= 4; c++) begin
         idle();
         result_ready = 1;
         if (c < 4) begin commit_valid = 1; commit_id = 4'(8 + c); end
         #1;
         if (c == 0) begin
            checks++; if (rv !== 1'b0) begin errors++; $display("FAIL b2b_first got=%b exp=0", rv); end
         end else begin
            checks++; if ({rv, result_id, result_data, result_rd} !== {1'b1, 4'(8 + c - 1), exp_d[c-1], 5'(20 + c - 1)}) begin
               errors++; $display("FAIL b2b_%0d got v=%b id=%0d data=%h rd=%0d exp v=1 id=%0d data=%h rd=%0d",
                                  c, rv, result_id, result_data, result_rd, 8 + c - 1, exp_d[c-1], 20 + c - 1);
            end
         end
         step();
      end
      #1;
      checks++; if ({rv, issue_ready} !== 2'b01) begin errors++; $display("FAIL b2b_drained got v=%b ready=%b exp v=0 ready=1", rv, issue_ready); end
   endtask

   task automatic test_hold_reset();
      set_issue(3'd0, 5'd9, 4'd3, 64'd10, 64'd20, 2'b11);
      commit_valid = 1; commit_id = 4'd3;
      #1;
      checks++; if (accept !== 1'b1) begin errors++; $display("FAIL same_cycle_commit_accept got=%b exp=1", accept); end
      step();
      idle(); result_ready = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if ({rv, result_id, result_data, result_rd, result_we} !== {1'b1, 4'd3, 64'd30, 5'd9, 1'b1}) begin
            errors++; $display("FAIL hold_%0d got v=%b id=%0d data=%0d rd=%0d we=%b exp v=1 id=3 data=30 rd=9 we=1",
                               k, rv, result_id, result_data, result_rd, result_we);
         end
         step();
      end
      #2 rst_n = 0;
      #1;
      checks++; if ({rv, issue_ready} !== 2'b01) begin errors++; $display("FAIL async_reset got v=%b ready=%b exp v=0 ready=1", rv, issue_ready); end
      do_reset();
   endtask

   task automatic test_random();
      logic [IDW-1:0]  nid;
      bit              used, ok, exp_acc, exp_rv;
      logic [XLEN-1:0] d;
      int              lat;
      int              cand[$];
      @(negedge clk);
      for (int n = 0; n < 600; n++) begin
         idle();
         if ($urandom_range(0, 99) < 60) begin
            do begin
               nid = 4'($urandom_range(0, 15));
               used = 0;
               foreach (mq[k]) if (mq[k].id == nid) used = 1;
            end while (used);
            set_issue(($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7)),
                      5'($urandom_range(0, 31)), nid, {$urandom, $urandom}, {$urandom, $urandom},
                      ($urandom_range(0, 9) < 8) ? 2'b11 : 2'($urandom_range(0, 2)));
            if ($urandom_range(0, 19) == 0) issue_instr[6:0] = 7'($urandom_range(0, 127));
         end
         if ($urandom_range(0, 99) < 50) begin
            commit_valid = 1;
            commit_kill  = ($urandom_range(0, 99) < 20);
            cand.delete();
            foreach (mq[k]) if (!mq[k].committed) cand.push_back(k);
            if (cand.size() > 0 && $urandom_range(0, 99) < 70)
               commit_id = mq[cand[$urandom_range(0, cand.size() - 1)]].id;
            else if (issue_valid && $urandom_range(0, 99) < 40)
               commit_id = issue_id;
            else
               commit_id = 4'($urandom_range(0, 15));
         end
         result_ready = ($urandom_range(0, 99) < 70);
         #1;
         ref_decode(issue_instr, rs_valid, rs, ok, d, lat);
         exp_acc = issue_valid && (mq.size() < DEPTH) && ok;
         exp_rv  = m_rv();
         checks++; if ({accept, wb} !== {exp_acc, exp_acc && (issue_instr[11:7] != 5'd0)}) begin
            errors++; $display("FAIL rand_accept n=%0d got=%b%b exp=%b%b", n, accept, wb, exp_acc, exp_acc && (issue_instr[11:7] != 5'd0));
         end
         checks++; if (issue_ready !== (mq.size() < DEPTH)) begin
            errors++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, issue_ready, (mq.size() < DEPTH));
         end
         checks++; if (rv !== exp_rv) begin errors++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, rv, exp_rv); end
         if (exp_rv) begin
            checks++; if ({result_id, result_data, result_rd, result_we} !== {mq[0].id, mq[0].data, mq[0].rd, mq[0].we}) begin
               errors++; $display("FAIL rand_result n=%0d got id=%0d data=%h rd=%0d we=%b exp id=%0d data=%h rd=%0d we=%b",
                                  n, result_id, result_data, result_rd, result_we, mq[0].id, mq[0].data, mq[0].rd, mq[0].we);
            end
         end
         step();
      end
   endtask

   initial begin
      rst_n = 0;
      result_ready = 1;
      idle();
      test_reset();
      test_add();
      test_mul();
      test_full();
      test_kill();
      test_reject_back_to_back();
      test_hold_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cvxif_copro_queue.md
# cvxif_copro_queue

Parametrised CV-X-IF coprocessor for the CVA6 subsystem, instantiated beside `cva6` when a coprocessor is configured. It extends the single-shot example coprocessor with a configurable-depth in-flight queue, speculative issue with commit/kill, and multi-cycle execution. Results return in order with a valid/ready handshake.

## Interface
- `XLEN`, 64: operand/result width.
- `IdWidth`, 4: instruction id width.
- `Depth`, 4: in-flight entries, ≥2.
- `NrRgprPorts`, 2: source register ports, 2 or 3.
- `MulLatency`, 3: MUL cycles from commit to result, ≥1.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `issue_valid_i` in 1: issue request.
- `issue_ready_o` out 1: queue not full.
- `issue_instr_i` in 32: instruction word.
- `issue_id_i` in IdWidth: instruction id.
- `rs_i` in NrRgprPorts*XLEN: source operands, rs1 in LSBs.
- `rs_valid_i` in NrRgprPorts: operand valid flags.
- `issue_accept_o` out 1: instruction accepted; valid during the issue handshake.
- `issue_writeback_o` out 1: accepted instruction writes rd.
- `commit_valid_i` in 1: commit event.
- `commit_id_i` in IdWidth: id being committed.
- `commit_kill_i` in 1: discard instead of execute.
- `result_valid_o` out 1: result available.
- `result_ready_i` in 1: core takes the result.
- `result_id_o` out IdWidth: result id.
- `result_data_o` out XLEN: result value.
- `result_rd_o` out 5: destination register.
- `result_we_o` out 1: register write enable.

## Operation
- Decode applies only to opcode 7'b0001011. funct3 selects the operation:
  - 000 ADD: rs1+rs2.
  - 001 SUB: rs1−rs2.
  - 010 XOR.
  - 011 MUL: low XLEN bits.
  - 100 ADD3: rs1+rs2+rs3. Legal only when NrRgprPorts==3.
- Any other encoding is rejected.
- Accept requires a legal encoding and rs_valid_i set for every operand the operation uses. Otherwise: accept=0, writeback=0, nothing enqueued.
- Handshake: a transaction occurs when issue_valid_i && issue_ready_o. issue_accept_o and issue_writeback_o are combinational in that cycle.
  - writeback = accept && rd!=0.
  - Both outputs are 0 whenever no handshake occurs.
- The result is computed at acceptance and stored. Arithmetic wraps modulo 2^XLEN.
- Entry states: WAIT_COMMIT → EXEC (latency counter) → DONE. A killed entry goes to KILLED.
- Commit:
  - commit_valid_i with an id matching a WAIT_COMMIT entry moves it to EXEC, or to KILLED if commit_kill_i is set.
  - A commit that matches the instruction being issued in the same cycle applies to it.
  - A commit with no matching id, or matching a non-WAIT entry, is ignored.
  - The issuer guarantees in-flight ids are unique.
- EXEC loads the counter with 1 (ADD/SUB/XOR/ADD3) or MulLatency (MUL). The counter decrements each cycle; the entry becomes DONE at 0.
- Retirement is strictly in order from the head:
  - Head DONE: result_valid_o=1 with the stored id, data and rd. result_we_o equals that entry's writeback.
  - Head popped on result_valid_o && result_ready_i.
  - Head KILLED: popped silently, one entry per cycle, with no result.
- Outputs stay stable while result_valid_o=1 and result_ready_i=0.
- issue_ready_o = (count < Depth). When full, a same-cycle pop does not enable a push.
- Reset mid-operation empties the queue immediately. Pending results and commits are lost.

## Timing
- Reset values:
  - issue_ready_o=1.
  - All other outputs 0.
  - Count 0, head/tail pointers 0, all entries invalid.
- Issue accepted in cycle T. Commit in cycle C≥T.
- Result latency: ALU result_valid_o earliest at C+1; MUL at C+MulLatency. Later if an older entry is still pending at the head.
- Back-to-back results are possible every cycle when consecutive head entries are DONE and result_ready_i=1.
- Count updates at the clock edge: +1 on push, −1 on pop (result or silent), net 0 on both.
- Pointers wrap modulo Depth. Depth need not be a power of two.
- Commit and result pop in the same cycle, for different entries, are both honoured.

## Test plan
- Issue ADD id=1, rs1=5, rs2=7, rd=3 → accept=1, writeback=1. Commit id=1 at cycle C → result at C+1: id=1, data=12, rd=3, we=1.
- Issue MUL id=2, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2, MulLatency=3, committed at C → result at C+3, data=0xFFFF_FFFF_FFFF_FFFE.
- Issue ids 0..3 (Depth=4) without commits → issue_ready_o=0 after the fourth issue. A fifth issue_valid_i gets no handshake and accept=0. Commit id 0 and drain → ready returns to 1.
- Issue id=4 (XOR) and id=5 (ADD). Kill id=4, commit id=5 → only the id=5 result appears, one cycle after the silent pop of id=4.
- Issue funct3=100 with NrRgprPorts=2, or rs_valid_i=2'b01 for ADD → accept=0, count unchanged.
- Hold result_ready_i=0 for 5 cycles with a DONE head → outputs stable. Assert rst_ni=0 mid-hold → result_valid_o=0, issue_ready_o=1 immediately.
